// File: rtl/led_serial_rx.sv
// Board-side receiver for the serial LED link: synchronizes the four link
// wires, shifts in MSB-first frames and latches complete frames onto led_par
// when the latch strobe rises. Short, long and stalled frames raise frame_err.
module led_serial_rx #(
  parameter  int DATA_W      = 16,
  parameter  int SYNC_STAGES = 2,
  parameter  int TIMEOUT     = 4096,
  localparam int CNT_W       = $clog2(DATA_W + 2),
  localparam int TO_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              led_clk,
  input  logic              led_sout,
  input  logic              led_clrn,
  input  logic              led_pen,
  output logic [DATA_W-1:0] led_par,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2,
    OVER = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  // Synchronizer chain, one lane per link wire: {pen, clrn, sout, clk}.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [1:0]                  edge_q, edge_d;   // {s_pen_d, s_clk_d}

  logic s_clk, s_sout, s_clrn, s_pen;
  logic clk_rise, pen_rise;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   led_par_q, led_par_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_err_q, frame_err_d;

  // Next value of each synchronizer stage; stage 0 samples the raw pins.
  always_comb begin
    sync_d[0] = {led_pen, led_clrn, led_sout, led_clk};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s_clk  = sync_q[SYNC_STAGES-1][0];
  assign s_sout = sync_q[SYNC_STAGES-1][1];
  assign s_clrn = sync_q[SYNC_STAGES-1][2];
  assign s_pen  = sync_q[SYNC_STAGES-1][3];

  assign edge_d   = {s_pen, s_clk};
  assign clk_rise = s_clk & ~edge_q[0];
  assign pen_rise = s_pen & ~edge_q[1];

  // Frame assembly, latch decision, clear and timeout handling.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    led_par_d     = led_par_q;
    to_cnt_d      = '0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (!s_clrn) begin
      // Clear wins over everything and never produces a pulse.
      shreg_d   = '0;
      bit_cnt_d = '0;
      state_d   = IDLE;
    end else begin
      // The shift is applied first so a coincident latch sees the new bit.
      if (clk_rise) begin
        shreg_d = (shreg_q << 1) | DATA_W'(s_sout);
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (bit_cnt_d == CNT_FULL) begin
          state_d = FULL;
        end else if (bit_cnt_d == CNT_MAX) begin
          state_d = OVER;
        end else begin
          state_d = RECV;
        end
      end

      if (pen_rise) begin
        unique case (state_d)
          FULL: begin
            led_par_d     = shreg_d;
            frame_valid_d = 1'b1;
          end
          RECV, OVER: frame_err_d = 1'b1;
          default:    ;
        endcase
        bit_cnt_d = '0;
        state_d   = IDLE;
      end else if (state_q != IDLE && !clk_rise) begin
        // A partial frame with a stalled link clock is abandoned.
        if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
    end
  end

  // State registers; reset discards everything immediately.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync_q        <= '0;
      edge_q        <= '0;
      state_q       <= IDLE;
      shreg_q       <= '0;
      led_par_q     <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q        <= sync_d;
      edge_q        <= edge_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      led_par_q     <= led_par_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign led_par     = led_par_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign bit_cnt     = bit_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule
